// File: rtl/cdma_wg_rd_pkg.sv
// Shared types, widths and helpers for the CDMA Winograd read-request generator.
// Holds the FSM state enum, payload widths, pd field offsets and the pd pack function.
package cdma_wg_rd_pkg;

  localparam int unsigned RD_ADDR_W  = 64;
  localparam int unsigned RD_SIZE_W  = 15;
  localparam int unsigned RD_PD_W    = RD_ADDR_W + RD_SIZE_W;
  localparam int unsigned STRIDE_W   = 32;
  localparam int unsigned LINE_CNT_W = 13;
  localparam int unsigned CREDIT_W   = 8;

  // pd layout: addr in the low bits, size above it
  localparam int unsigned RD_PD_ADDR_LSB = 0;
  localparam int unsigned RD_PD_SIZE_LSB = RD_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } wg_rd_state_e;

  typedef struct packed {
    logic [RD_SIZE_W-1:0] size;
    logic [RD_ADDR_W-1:0] addr;
  } rd_req_pd_t;

  function automatic logic [RD_PD_W-1:0] pack_rd_pd(input logic [RD_SIZE_W-1:0] size,
                                                    input logic [RD_ADDR_W-1:0] addr);
    logic [RD_PD_W-1:0] pd;
    pd = '0;
    pd[RD_PD_ADDR_LSB +: RD_ADDR_W] = addr;
    pd[RD_PD_SIZE_LSB +: RD_SIZE_W] = size;
    return pd;
  endfunction

endpackage

// File: rtl/cdma_wg_rd_req_gen_if.sv
// Read-request valid/ready bus between the generator and the WG read-request pipe.
//   dma_rd_req_vld : request valid (master -> slave)
//   dma_rd_req_pd  : {size, addr} payload (master -> slave)
//   dma_rd_req_rdy : downstream ready (slave -> master)
interface cdma_wg_rd_req_gen_if;

  logic                                dma_rd_req_vld;
  logic                                dma_rd_req_rdy;
  logic [cdma_wg_rd_pkg::RD_PD_W-1:0]  dma_rd_req_pd;

  modport master (
    output dma_rd_req_vld,
    output dma_rd_req_pd,
    input  dma_rd_req_rdy
  );

  modport slave (
    input  dma_rd_req_vld,
    input  dma_rd_req_pd,
    output dma_rd_req_rdy
  );

endinterface

// File: rtl/cdma_wg_rd_credit.sv
// Up/down outstanding-request counter.
//   clk, rst : clock, synchronous active-high reset
//   inc      : one request accepted
//   dec      : one request's data returned (ignored at zero)
//   avail    : registered, count < MAX_OUTSTANDING
//   zero     : registered, count == 0
module cdma_wg_rd_credit
  import cdma_wg_rd_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic avail,
  output logic zero
);

  logic [CREDIT_W-1:0] cnt_q;
  logic [CREDIT_W-1:0] cnt_nxt;

  // Simultaneous inc/dec cancel; a stray dec at zero is dropped
  always_comb begin
    cnt_nxt = cnt_q;
    if (inc && !dec) begin
      cnt_nxt = cnt_q + CREDIT_W'(1);
    end else if (!inc && dec && (cnt_q != '0)) begin
      cnt_nxt = cnt_q - CREDIT_W'(1);
    end
  end

  // Flags are computed from the next count so they line up with cnt_q
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      avail <= 1'b1;
      zero  <= 1'b1;
    end else begin
      cnt_q <= cnt_nxt;
      avail <= (cnt_nxt < CREDIT_W'(MAX_OUTSTANDING));
      zero  <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/cdma_wg_rd_req_gen.sv
// CDMA Winograd DMA read-request generator: walks surfaces x lines from the
// latched base/strides and emits one {size, addr} request per line, credit-limited.
//   nvdla_core_clk, nvdla_core_rst : clock, synchronous active-high reset
//   op_en                          : start pulse, sampled in IDLE only
//   reg2dp_*                       : layer config, latched on op_en
//   rsp_credit_ret                 : one outstanding request's data consumed
//   rd_req                         : request bus (master side)
//   busy                           : high outside IDLE
//   op_done                        : one-cycle pulse on return to IDLE
module cdma_wg_rd_req_gen
  import cdma_wg_rd_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  op_en,
  input  logic [RD_ADDR_W-1:0]  reg2dp_base_addr,
  input  logic [STRIDE_W-1:0]   reg2dp_line_stride,
  input  logic [STRIDE_W-1:0]   reg2dp_surf_stride,
  input  logic [LINE_CNT_W-1:0] reg2dp_line_num,
  input  logic [LINE_CNT_W-1:0] reg2dp_surf_num,
  input  logic [RD_SIZE_W-1:0]  reg2dp_line_size,
  input  logic                  rsp_credit_ret,
  output logic                  busy,
  output logic                  op_done,
  cdma_wg_rd_req_gen_if.master  rd_req
);

  wg_rd_state_e          state;
  logic [STRIDE_W-1:0]   line_stride_q;
  logic [STRIDE_W-1:0]   surf_stride_q;
  logic [LINE_CNT_W-1:0] line_num_q;
  logic [LINE_CNT_W-1:0] surf_num_q;
  logic [RD_SIZE_W-1:0]  size_q;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [LINE_CNT_W-1:0] surf_cnt;
  logic [RD_ADDR_W-1:0]  surf_addr;
  logic [RD_PD_W-1:0]    pd_q;

  logic                  credit_avail;
  logic                  credit_zero;
  logic                  accept;
  logic [RD_ADDR_W-1:0]  line_addr;
  logic [RD_ADDR_W-1:0]  line_addr_inc;
  logic [RD_ADDR_W-1:0]  surf_addr_inc;

  // vld is a decode of two flops only; rdy/credit_ret never reach it combinationally
  assign rd_req.dma_rd_req_vld = (state == ST_REQ) && credit_avail;
  assign rd_req.dma_rd_req_pd  = pd_q;
  assign accept                = rd_req.dma_rd_req_vld && rd_req.dma_rd_req_rdy;

  // The current line address lives in the pd register itself
  assign line_addr     = pd_q[RD_PD_ADDR_LSB +: RD_ADDR_W];
  assign line_addr_inc = line_addr + RD_ADDR_W'(line_stride_q);
  assign surf_addr_inc = surf_addr + RD_ADDR_W'(surf_stride_q);

  cdma_wg_rd_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .inc   (accept),
    .dec   (rsp_credit_ret),
    .avail (credit_avail),
    .zero  (credit_zero)
  );

  // Control FSM, line/surface counters and address accumulators
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      op_done       <= 1'b0;
      pd_q          <= '0;
      line_cnt      <= '0;
      surf_cnt      <= '0;
      surf_addr     <= '0;
      line_stride_q <= '0;
      surf_stride_q <= '0;
      line_num_q    <= '0;
      surf_num_q    <= '0;
      size_q        <= '0;
    end else begin
      op_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (op_en) begin
            state         <= ST_REQ;
            busy          <= 1'b1;
            line_stride_q <= reg2dp_line_stride;
            surf_stride_q <= reg2dp_surf_stride;
            line_num_q    <= reg2dp_line_num;
            surf_num_q    <= reg2dp_surf_num;
            size_q        <= reg2dp_line_size;
            line_cnt      <= '0;
            surf_cnt      <= '0;
            surf_addr     <= reg2dp_base_addr;
            pd_q          <= pack_rd_pd(reg2dp_line_size, reg2dp_base_addr);
          end
        end
        ST_REQ: begin
          if (accept) begin
            if (line_cnt == line_num_q) begin
              line_cnt <= '0;
              if (surf_cnt == surf_num_q) begin
                state <= ST_DRAIN;
              end else begin
                // next surface restarts the line walk at the new surface base
                surf_cnt  <= surf_cnt + LINE_CNT_W'(1);
                surf_addr <= surf_addr_inc;
                pd_q      <= pack_rd_pd(size_q, surf_addr_inc);
              end
            end else begin
              line_cnt <= line_cnt + LINE_CNT_W'(1);
              pd_q     <= pack_rd_pd(size_q, line_addr_inc);
            end
          end
        end
        ST_DRAIN: begin
          if (credit_zero) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            op_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdma_wg_rd_req_gen.sv
// Self-checking bench for cdma_wg_rd_req_gen (MAX_OUTSTANDING = 4).
// Expected addresses come from base + s*surf_stride + l*line_stride; credit and
// completion timing come from an outstanding-count model.
module tb_cdma_wg_rd_req_gen;
  import cdma_wg_rd_pkg::*;

  localparam int unsigned TB_MAX = 4;

  typedef struct {
    logic [63:0] base;
    logic [31:0] ls;
    logic [31:0] ss;
    logic [12:0] ln;
    logic [12:0] sn;
    logic [14:0] sz;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
    int          exp_n;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        op_en;
  logic        ret;
  logic [63:0] base;
  logic [31:0] ls;
  logic [31:0] ss;
  logic [12:0] ln;
  logic [12:0] sn;
  logic [14:0] lsz;
  logic        busy;
  logic        op_done;

  int errors = 0;
  int checks = 0;

  cdma_wg_rd_req_gen_if rd_if();

  cdma_wg_rd_req_gen #(.MAX_OUTSTANDING(TB_MAX)) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rst     (rst),
    .op_en              (op_en),
    .reg2dp_base_addr   (base),
    .reg2dp_line_stride (ls),
    .reg2dp_surf_stride (ss),
    .reg2dp_line_num    (ln),
    .reg2dp_surf_num    (sn),
    .reg2dp_line_size   (lsz),
    .rsp_credit_ret     (ret),
    .busy               (busy),
    .op_done            (op_done),
    .rd_req             (rd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_addr(input vec_t c, input int s, input int l);
    return c.base + 64'(s) * {32'h0, c.ss} + 64'(l) * {32'h0, c.ls};
  endfunction

  task automatic load_cfg(input vec_t c);
    base = c.base; ls = c.ls; ss = c.ss; ln = c.ln; sn = c.sn; lsz = c.sz;
  endtask

  // mode 0: rdy=1, every accept returned in the same cycle
  // mode 1: random rdy, random legal returns, stray op_en while busy, regs scrambled
  task automatic run_op(input vec_t c, input int mode, output int n_acc,
                        output logic [63:0] first_a, output logic [63:0] last_a,
                        output int first_cyc, output int done_cyc);
    int   total;
    int   lines;
    int   issued;
    int   cnt;
    int   cyc;
    bit   draining;
    bit   done_next;
    bit   exp_vld;
    logic rdy;
    logic acc;
    lines     = int'(c.ln) + 1;
    total     = lines * (int'(c.sn) + 1);
    issued    = 0;
    cnt       = 0;
    draining  = 1'b0;
    done_next = 1'b0;
    n_acc     = 0;
    first_a   = '0;
    last_a    = '0;
    first_cyc = -1;
    done_cyc  = -1;
    load_cfg(c);
    op_en = 1'b1;
    ret   = 1'b0;
    rd_if.dma_rd_req_rdy = 1'b0;
    step();
    cyc   = 1;
    op_en = 1'b0;
    if (mode == 1) begin
      base = {$urandom, $urandom}; ls = $urandom; ss = $urandom;
      ln = 13'($urandom); sn = 13'($urandom); lsz = 15'($urandom);
    end
    forever begin
      exp_vld = (issued < total) && (cnt < int'(TB_MAX));
      check("vld", 128'(rd_if.dma_rd_req_vld), 128'(exp_vld));
      if (exp_vld)
        check("pd", 128'(rd_if.dma_rd_req_pd),
              128'({c.sz, model_addr(c, issued / lines, issued % lines)}));
      check("op_done", 128'(op_done), 128'(done_next));
      if (done_next) begin
        check("busy_end", 128'(busy), 128'(0));
        done_cyc = cyc;
        break;
      end
      check("busy", 128'(busy), 128'(1));
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      acc = rd_if.dma_rd_req_vld && rdy;
      if (mode == 0) ret = acc;
      else           ret = ($urandom_range(0, 2) == 0) && ((cnt > 0) || acc);
      op_en = (mode == 1) && ($urandom_range(0, 3) == 0);
      rd_if.dma_rd_req_rdy = rdy;
      done_next = draining && (cnt == 0);
      if (acc) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_a   = rd_if.dma_rd_req_pd[63:0];
        end
        last_a = rd_if.dma_rd_req_pd[63:0];
        issued++;
        n_acc++;
        if (issued == total) draining = 1'b1;
      end
      cnt = cnt + int'(acc) - int'(ret);
      step();
      cyc++;
      if (cyc > 600) begin
        checks++;
        errors++;
        $display("FAIL op_timeout: no op_done after %0d cycles", cyc);
        break;
      end
    end
    op_en = 1'b0;
    ret   = 1'b0;
    rd_if.dma_rd_req_rdy = 1'b0;
  endtask

  vec_t        v[5];
  vec_t        cfg1;
  int          n;
  int          fc;
  int          dc;
  int          accs;
  logic [63:0] fa;
  logic [63:0] la;

  initial begin
    v[0] = '{64'h1000, 32'h100, 32'h1000, 13'd2, 13'd1, 15'd7,
             64'h1000, 64'h2200, 6};
    v[1] = '{64'hFFFF_FFFF_FFFF_FF00, 32'h100, 32'h0, 13'd1, 13'd0, 15'd3,
             64'hFFFF_FFFF_FFFF_FF00, 64'h0, 2};
    v[2] = '{64'h0, 32'h40, 32'h10000, 13'd0, 13'd2, 15'd1,
             64'h0, 64'h20000, 3};
    v[3] = '{64'h8000_0000, 32'hFFFF_FFFF, 32'h0, 13'd1, 13'd1, 15'h7FFF,
             64'h8000_0000, 64'h1_7FFF_FFFF, 4};
    v[4] = '{64'h1234_0000_0000, 32'h80, 32'h10000, 13'd3, 13'd2, 15'h20,
             64'h1234_0000_0000, 64'h1234_0002_0180, 12};
    cfg1 = v[0];

    rst = 1'b1; op_en = 1'b0; ret = 1'b0;
    rd_if.dma_rd_req_rdy = 1'b0;
    load_cfg(cfg1);
    step(); step();
    check("rst_vld", 128'(rd_if.dma_rd_req_vld), 128'(0));
    check("rst_pd", 128'(rd_if.dma_rd_req_pd), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_op_done", 128'(op_done), 128'(0));
    check("rst_credit", 128'(dut.u_credit.cnt_q), 128'(0));
    rst = 1'b0;
    step();

    // Basic walk at full rate: requests on cycles 1..6, op_done on cycle 8
    run_op(cfg1, 0, n, fa, la, fc, dc);
    check("basic_n", 128'(n), 128'(6));
    check("basic_first_cyc", 128'(fc), 128'(1));
    check("basic_done_cyc", 128'(dc), 128'(8));
    check("basic_last", 128'(la), 128'(64'h2200));

    // Table of configs under random backpressure and random returns
    for (int i = 0; i < 5; i++) begin
      run_op(v[i], 1, n, fa, la, fc, dc);
      check("tbl_n", 128'(n), 128'(v[i].exp_n));
      check("tbl_first", 128'(fa), 128'(v[i].exp_first));
      check("tbl_last", 128'(la), 128'(v[i].exp_last));
    end

    // Credit limit: no returns, so exactly TB_MAX requests go out
    load_cfg(cfg1);
    op_en = 1'b1; ret = 1'b0; rd_if.dma_rd_req_rdy = 1'b1;
    step();
    op_en = 1'b0;
    accs = 0;
    for (int i = 0; i < 8; i++) begin
      if (rd_if.dma_rd_req_vld) accs++;
      step();
    end
    check("credit_accepts", 128'(accs), 128'(TB_MAX));
    check("credit_stall_vld", 128'(rd_if.dma_rd_req_vld), 128'(0));
    check("credit_cnt_full", 128'(dut.u_credit.cnt_q), 128'(4));
    // one return lets exactly one more request out
    ret = 1'b1;
    step();
    ret = 1'b0;
    check("credit_ret_vld", 128'(rd_if.dma_rd_req_vld), 128'(1));
    check("credit_ret_pd", 128'(rd_if.dma_rd_req_pd), 128'({15'd7, 64'h2100}));
    step();
    check("credit_one_more", 128'(rd_if.dma_rd_req_vld), 128'(0));
    step();
    check("credit_hold_vld", 128'(rd_if.dma_rd_req_vld), 128'(0));
    check("credit_hold_cnt", 128'(dut.u_credit.cnt_q), 128'(4));
    // last request accepted in the same cycle as a return: count unchanged
    ret = 1'b1;
    step();
    check("credit_last_vld", 128'(rd_if.dma_rd_req_vld), 128'(1));
    check("credit_last_pd", 128'(rd_if.dma_rd_req_pd), 128'({15'd7, 64'h2200}));
    step();
    ret = 1'b0;
    check("credit_same_cycle", 128'(dut.u_credit.cnt_q), 128'(3));
    check("drain_vld", 128'(rd_if.dma_rd_req_vld), 128'(0));
    step();
    check("drain_no_done", 128'(op_done), 128'(0));
    check("drain_busy", 128'(busy), 128'(1));
    ret = 1'b1;
    step(); step(); step();
    ret = 1'b0;
    check("drain_zero_no_done", 128'(op_done), 128'(0));
    step();
    check("drain_done", 128'(op_done), 128'(1));
    check("drain_idle_busy", 128'(busy), 128'(0));
    step();
    check("done_pulse", 128'(op_done), 128'(0));
    // stray return at zero is ignored
    ret = 1'b1;
    step();
    ret = 1'b0;
    check("ret_at_zero", 128'(dut.u_credit.cnt_q), 128'(0));
    step();
    check("ret_at_zero_vld", 128'(rd_if.dma_rd_req_vld), 128'(0));

    // Reset mid-operation after three accepts
    load_cfg(cfg1);
    op_en = 1'b1; ret = 1'b0; rd_if.dma_rd_req_rdy = 1'b1;
    step();
    op_en = 1'b0;
    step(); step(); step();
    check("pre_rst_cnt", 128'(dut.u_credit.cnt_q), 128'(3));
    rd_if.dma_rd_req_rdy = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vld", 128'(rd_if.dma_rd_req_vld), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_credit", 128'(dut.u_credit.cnt_q), 128'(0));
    check("mid_rst_op_done", 128'(op_done), 128'(0));
    step();
    check("post_rst_op_done", 128'(op_done), 128'(0));
    run_op(cfg1, 0, n, fa, la, fc, dc);
    check("restart_first", 128'(fa), 128'(64'h1000));
    check("restart_n", 128'(n), 128'(6));
    check("restart_done_cyc", 128'(dc), 128'(8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
